// File: rtl/next_sram_pkg.sv
// Shared types and helpers for the "next"-pointer SRAM model.
// Holds default geometry, the clear-engine state type and the lane-mask expander.
package next_sram_pkg;

  localparam int DEF_DEPTH  = 16;
  localparam int DEF_Q      = 16;
  localparam int DEF_BW     = 4;

  // Upper bounds for expand_mask; callers zero-extend their mask and truncate the result.
  localparam int MASK_MAX_Q = 64;
  localparam int MASK_MAX_W = 1024;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  function automatic logic [MASK_MAX_W-1:0] expand_mask(input logic [MASK_MAX_Q-1:0] mask,
                                                        input int bw);
    logic [MASK_MAX_W-1:0] bits;
    bits = '0;
    for (int i = 0; i < MASK_MAX_W; i++) begin
      if ((i / bw) < MASK_MAX_Q) bits[i] = mask[i / bw];
    end
    return bits;
  endfunction

endpackage

// File: rtl/next_sram_param_if.sv
// Bus bundle for next_sram_param: write port, read port and clear-engine handshake.
interface next_sram_param_if
  import next_sram_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int Q     = DEF_Q,
  parameter int BW    = DEF_BW
);
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic              wsb;
  logic [BW*Q-1:0]   wdata;
  logic [Q-1:0]      bytemask;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W-1:0] raddr;
  logic [BW*Q-1:0]   rdata;
  logic              clr_req;
  logic              clr_busy;
  logic              clr_done;

  modport master (
    output wsb, wdata, bytemask, waddr, raddr, clr_req,
    input  rdata, clr_busy, clr_done
  );

  modport slave (
    input  wsb, wdata, bytemask, waddr, raddr, clr_req,
    output rdata, clr_busy, clr_done
  );

endinterface

// File: rtl/next_sram_clr_fsm.sv
// Clear engine: sweeps every address once after reset or on clr_req,
// supplying write enable/address to the array and busy/done status.
module next_sram_clr_fsm
  import next_sram_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr_req,
  output logic              o_clr_we,
  output logic [ADDR_W-1:0] o_clr_addr,
  output logic              o_busy,
  output logic              o_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // clr_req during a sweep is ignored; done is suppressed while reset holds the sweep at 0.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_clr_req) begin
          w_state_nxt = S_CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      S_CLEAR: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == LAST_ADDR) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          o_done      = !rst;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign o_clr_we   = (r_state == S_CLEAR);
  assign o_clr_addr = r_cnt;
  assign o_busy     = (r_state == S_CLEAR) || rst;

endmodule

// File: rtl/next_sram_param.sv
// Behavioural SRAM for graph-engine "next" pointers: masked write port, registered read port,
// built-in clear sweep. Define NEXT_SRAM_WR_BYPASS_EN for same-cycle write-to-read bypass.
module next_sram_param
  import next_sram_pkg::*;
#(
  parameter int          DEPTH    = DEF_DEPTH,
  parameter int          Q        = DEF_Q,
  parameter int          BW       = DEF_BW,
  parameter logic [BW-1:0] INIT_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  next_sram_param_if.slave bus
);

  localparam int            ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int            W         = BW * Q;
  localparam logic [W-1:0]  INIT_WORD = {Q{INIT_VAL}};

  logic [W-1:0]      r_mem [DEPTH];
  logic [W-1:0]      r_rdata;
  logic [W-1:0]      w_mask;
  logic [W-1:0]      w_wr_word;
  logic [W-1:0]      w_rd_word;
  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_busy;
  logic              w_done;
  logic              w_waddr_ok;
  logic              w_raddr_ok;
  logic              w_wr_ok;

  next_sram_clr_fsm #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clr_fsm (
    .clk        (clk),
    .rst        (rst),
    .i_clr_req  (bus.clr_req),
    .o_clr_we   (w_clr_we),
    .o_clr_addr (w_clr_addr),
    .o_busy     (w_busy),
    .o_done     (w_done)
  );

  // Extra MSB keeps the range check meaningful when DEPTH is a power of two.
  assign w_waddr_ok = ({1'b0, bus.waddr} < (ADDR_W + 1)'(DEPTH));
  assign w_raddr_ok = ({1'b0, bus.raddr} < (ADDR_W + 1)'(DEPTH));

  assign w_mask     = W'(expand_mask(MASK_MAX_Q'(bus.bytemask), BW));
  assign w_wr_ok    = !w_busy && !bus.wsb && w_waddr_ok;
  assign w_wr_word  = (bus.wdata & ~w_mask) | (r_mem[bus.waddr] & w_mask);

  always_comb begin
    w_rd_word = '0;
    if (w_raddr_ok) begin
      w_rd_word = r_mem[bus.raddr];
`ifdef NEXT_SRAM_WR_BYPASS_EN
      if (w_wr_ok && (bus.waddr == bus.raddr)) begin
        w_rd_word = w_wr_word;
      end else if (w_clr_we && (w_clr_addr == bus.raddr)) begin
        w_rd_word = INIT_WORD;
      end
`endif
    end
  end

  // Write stage: the clear engine owns the array while sweeping.
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[w_clr_addr] <= INIT_WORD;
    end else if (w_wr_ok) begin
      r_mem[bus.waddr] <= w_wr_word;
    end
  end

  // Read stage
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else begin
      r_rdata <= w_rd_word;
    end
  end

  assign bus.rdata    = r_rdata;
  assign bus.clr_busy = w_busy;
  assign bus.clr_done = w_done;

  // Backdoor preload for simulation; bypasses the FSM entirely.
  task automatic load_param(input int index, input logic [W-1:0] value);
    if (index >= 0 && index < DEPTH) r_mem[index] <= value;
  endtask

endmodule

// File: tb/tb_next_sram_param.sv
// Self-checking bench for next_sram_param: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the memory and clear sweep.
module tb_next_sram_param;

  localparam int          DEPTH     = 16;
  localparam int          Q         = 16;
  localparam int          BW        = 4;
  localparam logic [3:0]  INIT      = 4'hF;
  localparam logic [63:0] INIT_WORD = {16{4'hF}};

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] mem_m [DEPTH];
  bit          busy_m = 1'b0;
  int          pos_m  = 0;
  logic [63:0] exp_rd;
  int          busy_seen = 0;
  int          done_seen = 0;

  next_sram_param_if #(.DEPTH(DEPTH), .Q(Q), .BW(BW)) bus ();

  next_sram_param #(
    .DEPTH    (DEPTH),
    .Q        (Q),
    .BW       (BW),
    .INIT_VAL (INIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // One clock cycle: check status before the edge, advance the model, check rdata after it.
  task automatic tick();
    logic [63:0] merged;
    logic [63:0] rd;
    bit          wr;
    int          wa;
    int          ra;
    #1;
    check1("clr_busy", bus.clr_busy, busy_m || rst);
    check1("clr_done", bus.clr_done, busy_m && (pos_m == DEPTH - 1) && !rst);
    if (bus.clr_busy) busy_seen++;
    if (bus.clr_done) done_seen++;
    wa = int'(bus.waddr);
    ra = int'(bus.raddr);
    wr = !busy_m && !rst && !bus.wsb && (wa < DEPTH);
    merged = (wa < DEPTH) ? mem_m[wa] : 64'h0;
    for (int l = 0; l < Q; l++) begin
      if (!bus.bytemask[l]) merged[BW*l +: BW] = bus.wdata[BW*l +: BW];
    end
    rd = (ra < DEPTH) ? mem_m[ra] : 64'h0;
`ifdef NEXT_SRAM_WR_BYPASS_EN
    if (wr && wa == ra) rd = merged;
    else if (busy_m && pos_m == ra) rd = INIT_WORD;
`endif
    @(posedge clk);
    #1;
    if (busy_m) begin
      mem_m[pos_m] = INIT_WORD;
      if (pos_m == DEPTH - 1) busy_m = 1'b0;
      else pos_m++;
    end else begin
      if (wr) mem_m[wa] = merged;
      if (bus.clr_req && !rst) begin
        busy_m = 1'b1;
        pos_m  = 0;
      end
    end
    if (rst) begin
      busy_m = 1'b1;
      pos_m  = 0;
      rd     = 64'h0;
    end
    exp_rd = rd;
    check64("rdata", bus.rdata, exp_rd);
  endtask

  // Run while busy (bounded); random dropped writes, optional random reads, clr_req at req_at.
  task automatic sweep_loop(input bit rnd_rd, input int req_at);
    for (int i = 0; i < 40 && bus.clr_busy; i++) begin
      bus.clr_req = (i == req_at);
      bus.wsb     = 1'($urandom_range(0, 1));
      bus.waddr   = 4'($urandom);
      bus.wdata   = {$urandom(), $urandom()};
      bus.bytemask = 16'($urandom);
      if (rnd_rd) bus.raddr = 4'($urandom);
      tick();
    end
    bus.clr_req = 1'b0;
    bus.wsb     = 1'b1;
  endtask

  task automatic read_all_init(input string tag);
    for (int a = 0; a < DEPTH; a++) begin
      bus.raddr = 4'(a);
      tick();
      check64(tag, bus.rdata, INIT_WORD);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 'x;
    bus.wsb      = 1'b1;
    bus.wdata    = '0;
    bus.bytemask = '1;
    bus.waddr    = '0;
    bus.raddr    = '0;
    bus.clr_req  = 1'b0;
    rst          = 1'b1;

    // Reset held three cycles, then the automatic sweep.
    repeat (3) tick();
    rst = 1'b0;
    busy_seen = 0;
    done_seen = 0;
    sweep_loop(1'b0, -1);
    check_int("auto_clear_cycles", busy_seen, 16);
    check_int("auto_clear_done", done_seen, 1);
    read_all_init("auto_clear_word");

    // Masked write over a backdoor-preloaded word.
    dut.load_param(5, 64'h0123_4567_89AB_CDEF);
    mem_m[5] = 64'h0123_4567_89AB_CDEF;
    bus.wsb = 1'b0; bus.waddr = 4'd5; bus.wdata = '1; bus.bytemask = 16'hFF00; bus.raddr = 4'd0;
    tick();
    bus.wsb = 1'b1; bus.raddr = 4'd5;
    tick();
    check64("masked_write", bus.rdata, 64'h0123_4567_FFFF_FFFF);

    // Read latency and hold.
    bus.wsb = 1'b0; bus.waddr = 4'd3; bus.wdata = 64'hA5A5_A5A5_A5A5_A5A5; bus.bytemask = '0;
    bus.raddr = 4'd4;
    tick();
    check64("lat_other_addr", bus.rdata, INIT_WORD);
    bus.wsb = 1'b1; bus.raddr = 4'd3;
    tick();
    check64("lat_one_edge", bus.rdata, 64'hA5A5_A5A5_A5A5_A5A5);
    tick();
    check64("lat_hold", bus.rdata, 64'hA5A5_A5A5_A5A5_A5A5);

    // Same-cycle write/read collision on address 7.
    bus.wsb = 1'b0; bus.waddr = 4'd7; bus.wdata = '0; bus.bytemask = '0;
    tick();
    bus.wdata = 64'h1111_1111_1111_1111; bus.raddr = 4'd7;
    tick();
`ifdef NEXT_SRAM_WR_BYPASS_EN
    check64("collision", bus.rdata, 64'h1111_1111_1111_1111);
`else
    check64("collision", bus.rdata, 64'h0);
`endif
    bus.wsb = 1'b1;
    tick();
    check64("collision_after", bus.rdata, 64'h1111_1111_1111_1111);

    // Requested clear, write in the request cycle, writes and a repeat request during busy.
    bus.wsb = 1'b0; bus.waddr = 4'd2; bus.wdata = {$urandom(), $urandom()}; bus.clr_req = 1'b1;
    tick();
    busy_seen = 0;
    done_seen = 0;
    sweep_loop(1'b1, 4);
    check_int("req_clear_cycles", busy_seen, 16);
    check_int("req_clear_done", done_seen, 1);
    read_all_init("req_clear_word");

    // Reset in the middle of a sweep restarts it.
    bus.clr_req = 1'b1;
    tick();
    bus.clr_req = 1'b0;
    repeat (8) tick();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    busy_seen = 0;
    done_seen = 0;
    sweep_loop(1'b1, -1);
    check_int("rst_mid_cycles", busy_seen, 16);
    check_int("rst_mid_done", done_seen, 1);

    // Randomized traffic with occasional clear requests.
    repeat (300) begin
      bus.wsb      = 1'($urandom_range(0, 1));
      bus.waddr    = 4'($urandom);
      bus.raddr    = 4'($urandom);
      bus.wdata    = {$urandom(), $urandom()};
      bus.bytemask = 16'($urandom);
      bus.clr_req  = ($urandom_range(0, 29) == 0);
      tick();
    end
    bus.clr_req = 1'b0;
    bus.wsb     = 1'b1;
    repeat (DEPTH + 2) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
